// File: rtl/seg_instruction_decode.sv
// MIPS decode stage: IF/ID latch, register file, decoder, hazard unit and ID/EX latch.
// Branches and jumps resolve here and drive the fetch PC mux.
module seg_instruction_decode #(
  parameter int LEN         = 32,
  parameter int NB_REG_ADDR = 5,
  parameter int N_REGS      = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [LEN-1:0]         i_instruction,
  input  logic [LEN-1:0]         i_PC,
  input  logic                   i_wb_reg_write,
  input  logic [NB_REG_ADDR-1:0] i_wb_addr,
  input  logic [LEN-1:0]         i_wb_data,
  input  logic                   i_exmem_reg_write,
  input  logic [NB_REG_ADDR-1:0] i_exmem_rd,
  output logic                   o_PC_write,
  output logic [LEN-1:0]         o_PC_branch,
  output logic                   o_PCSrc,
  output logic [LEN-1:0]         o_PC_dir_jump,
  output logic                   o_jump,
  output logic [LEN-1:0]         o_npc,
  output logic [LEN-1:0]         o_rs_data,
  output logic [LEN-1:0]         o_rt_data,
  output logic [LEN-1:0]         o_imm,
  output logic [NB_REG_ADDR-1:0] o_rs,
  output logic [NB_REG_ADDR-1:0] o_rt,
  output logic [NB_REG_ADDR-1:0] o_rd,
  output logic [5:0]             o_opcode,
  output logic [5:0]             o_funct,
  output logic                   o_reg_write,
  output logic                   o_mem_read,
  output logic                   o_mem_write,
  output logic                   o_mem_to_reg,
  output logic                   o_alu_src,
  output logic                   o_reg_dst,
  output logic                   o_link
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  logic [LEN-1:0]         ifid_instr;
  logic [LEN-1:0]         ifid_npc;
  logic [LEN-1:0]         regs [N_REGS];

  logic [5:0]             opcode;
  logic [5:0]             funct;
  logic [NB_REG_ADDR-1:0] rs;
  logic [NB_REG_ADDR-1:0] rt;
  logic [NB_REG_ADDR-1:0] rd;
  logic [NB_REG_ADDR-1:0] idex_dest;
  logic [15:0]            imm16;
  logic [LEN-1:0]         rs_val;
  logic [LEN-1:0]         rt_val;
  logic [LEN-1:0]         sext_imm;
  logic [LEN-1:0]         imm_ext;

  logic c_reg_write, c_mem_read, c_mem_write, c_mem_to_reg, c_alu_src, c_reg_dst, c_link;
  logic is_beq, is_bne, is_j, is_jal, is_jr, zext;
  logic load_use, branch_hazard, stall, take_branch, take_jump;

  assign opcode   = ifid_instr[31:26];
  assign rs       = ifid_instr[25:21];
  assign rt       = ifid_instr[20:16];
  assign rd       = ifid_instr[15:11];
  assign funct    = ifid_instr[5:0];
  assign imm16    = ifid_instr[15:0];
  assign sext_imm = {{(LEN-16){imm16[15]}}, imm16};
  assign imm_ext  = zext ? {{(LEN-16){1'b0}}, imm16} : sext_imm;

  // Register reads with write-through bypass; r0 is hard-wired to zero.
  always_comb begin
    rs_val = regs[rs];
    rt_val = regs[rt];
    if (rs == '0) begin
      rs_val = '0;
    end else if (i_wb_reg_write && (i_wb_addr == rs)) begin
      rs_val = i_wb_data;
    end else begin
      rs_val = regs[rs];
    end
    if (rt == '0) begin
      rt_val = '0;
    end else if (i_wb_reg_write && (i_wb_addr == rt)) begin
      rt_val = i_wb_data;
    end else begin
      rt_val = regs[rt];
    end
  end

  // Main decoder; the all-zero word (flush NOP) carries no control at all.
  always_comb begin
    c_reg_write  = 1'b0;
    c_mem_read   = 1'b0;
    c_mem_write  = 1'b0;
    c_mem_to_reg = 1'b0;
    c_alu_src    = 1'b0;
    c_reg_dst    = 1'b0;
    c_link       = 1'b0;
    is_beq       = 1'b0;
    is_bne       = 1'b0;
    is_j         = 1'b0;
    is_jal       = 1'b0;
    is_jr        = 1'b0;
    zext         = 1'b0;
    if (ifid_instr != '0) begin
      case (opcode)
        OP_RTYPE: begin
          if (funct == FN_JR) begin
            is_jr = 1'b1;
          end else begin
            c_reg_write = 1'b1;
            c_reg_dst   = 1'b1;
          end
        end
        OP_LW: begin
          c_reg_write  = 1'b1;
          c_mem_read   = 1'b1;
          c_mem_to_reg = 1'b1;
          c_alu_src    = 1'b1;
        end
        OP_SW: begin
          c_mem_write = 1'b1;
          c_alu_src   = 1'b1;
        end
        OP_ADDI, OP_SLTI, OP_LUI: begin
          c_reg_write = 1'b1;
          c_alu_src   = 1'b1;
        end
        OP_ANDI, OP_ORI: begin
          c_reg_write = 1'b1;
          c_alu_src   = 1'b1;
          zext        = 1'b1;
        end
        OP_BEQ: is_beq = 1'b1;
        OP_BNE: is_bne = 1'b1;
        OP_J:   is_j   = 1'b1;
        OP_JAL: begin
          is_jal      = 1'b1;
          c_reg_write = 1'b1;
          c_reg_dst   = 1'b1;
          c_link      = 1'b1;
        end
        default: begin
          c_reg_write = 1'b0;
        end
      endcase
    end else begin
      c_reg_write = 1'b0;
    end
  end

  // Hazards: load-use against ID/EX, and branch/JR operands still being produced in EX or MEM.
  assign idex_dest     = o_reg_dst ? o_rd : o_rt;
  assign load_use      = o_mem_read && (o_rt != '0) && ((o_rt == rs) || (o_rt == rt));
  assign branch_hazard = (is_beq || is_bne || is_jr) &&
                         ((o_reg_write && (idex_dest != '0) && ((idex_dest == rs) || (idex_dest == rt))) ||
                          (i_exmem_reg_write && (i_exmem_rd != '0) && ((i_exmem_rd == rs) || (i_exmem_rd == rt))));
  assign stall         = load_use || branch_hazard;

  assign take_branch   = !stall && ((is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val)));
  assign take_jump     = !stall && (is_j || is_jal || is_jr);

  assign o_PC_write    = !stall;
  assign o_PCSrc       = take_branch;
  assign o_jump        = take_jump;
  assign o_PC_branch   = ifid_npc + sext_imm;
  assign o_PC_dir_jump = is_jr ? rs_val : {{(LEN-26){1'b0}}, ifid_instr[25:0]};

  // IF/ID latch: hold on stall, squash to NOP on a taken branch/jump.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ifid_instr <= '0;
      ifid_npc   <= '0;
    end else if (stall) begin
      ifid_instr <= ifid_instr;
      ifid_npc   <= ifid_npc;
    end else if (take_branch || take_jump) begin
      ifid_instr <= '0;
      ifid_npc   <= ifid_npc;
    end else begin
      ifid_instr <= i_instruction;
      ifid_npc   <= i_PC + {{(LEN-1){1'b0}}, 1'b1};
    end
  end

  // Register file write port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (i_wb_reg_write && (i_wb_addr != '0)) begin
      regs[i_wb_addr] <= i_wb_data;
    end else begin
      regs[0] <= '0;
    end
  end

  // ID/EX latch; a stall inserts an all-zero bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst || stall) begin
      o_npc        <= '0;
      o_rs_data    <= '0;
      o_rt_data    <= '0;
      o_imm        <= '0;
      o_rs         <= '0;
      o_rt         <= '0;
      o_rd         <= '0;
      o_opcode     <= 6'h00;
      o_funct      <= 6'h00;
      o_reg_write  <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_alu_src    <= 1'b0;
      o_reg_dst    <= 1'b0;
      o_link       <= 1'b0;
    end else begin
      o_npc        <= ifid_npc;
      o_rs_data    <= rs_val;
      o_rt_data    <= rt_val;
      o_imm        <= imm_ext;
      o_rs         <= rs;
      o_rt         <= rt;
      o_rd         <= is_jal ? {NB_REG_ADDR{1'b1}} : rd;
      o_opcode     <= opcode;
      o_funct      <= funct;
      o_reg_write  <= c_reg_write;
      o_mem_read   <= c_mem_read;
      o_mem_write  <= c_mem_write;
      o_mem_to_reg <= c_mem_to_reg;
      o_alu_src    <= c_alu_src;
      o_reg_dst    <= c_reg_dst;
      o_link       <= c_link;
    end
  end

endmodule

// File: tb/tb_seg_instruction_decode.sv
// Directed bench for seg_instruction_decode: inputs change on the falling edge, outputs are checked there.
module tb_seg_instruction_decode;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_instruction;
  logic [31:0] i_PC;
  logic        i_wb_reg_write;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        i_exmem_reg_write;
  logic [4:0]  i_exmem_rd;
  logic        o_PC_write;
  logic [31:0] o_PC_branch;
  logic        o_PCSrc;
  logic [31:0] o_PC_dir_jump;
  logic        o_jump;
  logic [31:0] o_npc;
  logic [31:0] o_rs_data;
  logic [31:0] o_rt_data;
  logic [31:0] o_imm;
  logic [4:0]  o_rs;
  logic [4:0]  o_rt;
  logic [4:0]  o_rd;
  logic [5:0]  o_opcode;
  logic [5:0]  o_funct;
  logic        o_reg_write;
  logic        o_mem_read;
  logic        o_mem_write;
  logic        o_mem_to_reg;
  logic        o_alu_src;
  logic        o_reg_dst;
  logic        o_link;

  int checks = 0;
  int errors = 0;

  seg_instruction_decode dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_instruction(i_instruction), .i_PC(i_PC),
    .i_wb_reg_write(i_wb_reg_write), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_exmem_reg_write(i_exmem_reg_write), .i_exmem_rd(i_exmem_rd),
    .o_PC_write(o_PC_write), .o_PC_branch(o_PC_branch), .o_PCSrc(o_PCSrc),
    .o_PC_dir_jump(o_PC_dir_jump), .o_jump(o_jump), .o_npc(o_npc),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm(o_imm),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_opcode(o_opcode), .o_funct(o_funct),
    .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_to_reg(o_mem_to_reg), .o_alu_src(o_alu_src), .o_reg_dst(o_reg_dst), .o_link(o_link)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    i_instruction = instr;
    i_PC          = pc;
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    i_wb_reg_write = en;
    i_wb_addr      = addr;
    i_wb_data      = data;
  endtask

  initial begin
    i_rst = 1'b1;
    drive(32'h0000_0000, 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    i_exmem_reg_write = 1'b0;
    i_exmem_rd        = 5'd0;
    tick();
    tick();
    i_rst = 1'b0;
    chk("rst_pc_write", {31'd0, o_PC_write}, 32'd1);
    chk("rst_pcsrc", {31'd0, o_PCSrc}, 32'd0);
    chk("rst_jump", {31'd0, o_jump}, 32'd0);
    chk("rst_reg_write", {31'd0, o_reg_write}, 32'd0);
    chk("rst_npc", o_npc, 32'd0);

    // ADDI r1,r0,5 at PC 0
    drive(32'h2001_0005, 32'd0); tick();
    drive(32'h0000_0000, 32'd1); tick();
    chk("addi_reg_write", {31'd0, o_reg_write}, 32'd1);
    chk("addi_alu_src", {31'd0, o_alu_src}, 32'd1);
    chk("addi_rt", {27'd0, o_rt}, 32'd1);
    chk("addi_imm", o_imm, 32'd5);
    chk("addi_npc", o_npc, 32'd1);
    chk("addi_reg_dst", {31'd0, o_reg_dst}, 32'd0);

    // ANDI zero-extends, ADDI sign-extends the same immediate
    drive(32'h3005_8000, 32'd2); tick();
    drive(32'h2005_8000, 32'd3); tick();
    chk("andi_imm_zext", o_imm, 32'h0000_8000);
    drive(32'hFC22_1234, 32'd4); tick();
    chk("addi_imm_sext", o_imm, 32'hFFFF_8000);
    drive(32'h0000_0000, 32'd5); tick();
    chk("unknown_reg_write", {31'd0, o_reg_write}, 32'd0);
    chk("unknown_alu_src", {31'd0, o_alu_src}, 32'd0);
    chk("unknown_mem_write", {31'd0, o_mem_write}, 32'd0);

    // ADD r5,r3,r0 while write-back writes r3
    drive(32'h0060_2820, 32'd6); tick();
    drive(32'h0000_0000, 32'd7);
    wb(1'b1, 5'd3, 32'hDEAD_BEEF); tick();
    wb(1'b0, 5'd0, 32'd0);
    chk("bypass_rs_data", o_rs_data, 32'hDEAD_BEEF);
    chk("add_rd", {27'd0, o_rd}, 32'd5);
    chk("add_reg_dst", {31'd0, o_reg_dst}, 32'd1);

    // ADD r6,r0,r3 while write-back targets r0
    drive(32'h0003_3020, 32'd8); tick();
    drive(32'h0000_0000, 32'd9);
    wb(1'b1, 5'd0, 32'h1234_5678); tick();
    wb(1'b1, 5'd1, 32'd5);
    chk("r0_rs_data", o_rs_data, 32'd0);
    chk("r3_stored", o_rt_data, 32'hDEAD_BEEF);
    tick();
    wb(1'b0, 5'd0, 32'd0);

    // LW r2,0(r0) then ADD r4,r2,r2: exactly one stall cycle
    drive(32'h8C02_0000, 32'd2); tick();
    drive(32'h0042_2020, 32'd3); tick();
    chk("lw_mem_read", {31'd0, o_mem_read}, 32'd1);
    chk("lw_mem_to_reg", {31'd0, o_mem_to_reg}, 32'd1);
    chk("lw_rs_data_r0", o_rs_data, 32'd0);
    chk("loaduse_stall", {31'd0, o_PC_write}, 32'd0);
    tick();
    chk("bubble_reg_write", {31'd0, o_reg_write}, 32'd0);
    chk("bubble_mem_read", {31'd0, o_mem_read}, 32'd0);
    chk("bubble_mem_to_reg", {31'd0, o_mem_to_reg}, 32'd0);
    chk("after_bubble_pc_write", {31'd0, o_PC_write}, 32'd1);
    drive(32'h0000_0000, 32'd4); tick();
    chk("add_issue_rd", {27'd0, o_rd}, 32'd4);
    chk("add_issue_reg_write", {31'd0, o_reg_write}, 32'd1);
    chk("no_extra_stall", {31'd0, o_PC_write}, 32'd1);

    // BEQ r1,r1,+3 at PC 10
    drive(32'h1021_0003, 32'd10); tick();
    chk("beq_pcsrc", {31'd0, o_PCSrc}, 32'd1);
    chk("beq_target", o_PC_branch, 32'd14);
    chk("beq_pc_write", {31'd0, o_PC_write}, 32'd1);
    drive(32'h2001_0005, 32'd11); tick();
    chk("beq_in_idex", {26'd0, o_opcode}, 32'd4);
    chk("flush_pcsrc", {31'd0, o_PCSrc}, 32'd0);
    drive(32'h0000_0000, 32'd14); tick();
    chk("flush_alu_src", {31'd0, o_alu_src}, 32'd0);
    chk("flush_reg_write", {31'd0, o_reg_write}, 32'd0);
    chk("flush_npc_held", o_npc, 32'd11);

    // BEQ r0,r0,-16 at PC 5 wraps below zero
    drive(32'h1000_FFF0, 32'd5); tick();
    chk("beq_neg_target", o_PC_branch, 32'hFFFF_FFF6);
    chk("beq_neg_pcsrc", {31'd0, o_PCSrc}, 32'd1);
    drive(32'h0000_0000, 32'hFFFF_FFF6); tick();

    // BNE equal operands, then BNE r1,r0 blocked by EX/MEM writing r1
    drive(32'h1421_0002, 32'd20); tick();
    chk("bne_eq_pcsrc", {31'd0, o_PCSrc}, 32'd0);
    chk("bne_eq_pc_write", {31'd0, o_PC_write}, 32'd1);
    drive(32'h1420_0004, 32'd21); tick();
    i_exmem_reg_write = 1'b1;
    i_exmem_rd        = 5'd1;
    #1;
    chk("bne_haz_stall", {31'd0, o_PC_write}, 32'd0);
    chk("bne_haz_pcsrc", {31'd0, o_PCSrc}, 32'd0);
    tick();
    chk("bne_haz_stall2", {31'd0, o_PC_write}, 32'd0);
    chk("bne_haz_pcsrc2", {31'd0, o_PCSrc}, 32'd0);
    i_exmem_reg_write = 1'b0;
    i_exmem_rd        = 5'd0;
    #1;
    chk("bne_clear_pcsrc", {31'd0, o_PCSrc}, 32'd1);
    chk("bne_clear_target", o_PC_branch, 32'd26);
    chk("bne_clear_pc_write", {31'd0, o_PC_write}, 32'd1);
    drive(32'h0000_0000, 32'd26); tick();

    // JAL 0x100 at PC 7, then JR r31
    drive(32'h0C00_0100, 32'd7); tick();
    chk("jal_jump", {31'd0, o_jump}, 32'd1);
    chk("jal_target", o_PC_dir_jump, 32'h0000_0100);
    drive(32'h2001_0005, 32'd8); tick();
    chk("jal_rd", {27'd0, o_rd}, 32'd31);
    chk("jal_link", {31'd0, o_link}, 32'd1);
    chk("jal_reg_write", {31'd0, o_reg_write}, 32'd1);
    chk("jal_npc", o_npc, 32'd8);
    chk("jal_flush_jump", {31'd0, o_jump}, 32'd0);
    drive(32'h03E0_0008, 32'h0000_0100);
    wb(1'b1, 5'd31, 32'd8); tick();
    wb(1'b0, 5'd0, 32'd0);
    chk("jr_jump", {31'd0, o_jump}, 32'd1);
    chk("jr_target", o_PC_dir_jump, 32'd8);
    chk("jr_pc_write", {31'd0, o_PC_write}, 32'd1);
    drive(32'h0000_0000, 32'd8); tick();

    // Reset in the middle of a load-use stall
    drive(32'h8C02_0000, 32'd30); tick();
    drive(32'h0042_2020, 32'd31); tick();
    chk("pre_rst_stall", {31'd0, o_PC_write}, 32'd0);
    i_rst = 1'b1; tick();
    i_rst = 1'b0;
    chk("rst_stall_cleared", {31'd0, o_PC_write}, 32'd1);
    chk("rst_mem_read", {31'd0, o_mem_read}, 32'd0);
    chk("rst_rt", {27'd0, o_rt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_instruction_decode.md
Name: seg_instruction_decode

Overview:
Decode stage of the 5-stage MIPS pipeline, directly downstream of seg_instruction_fetch.
- Contains the IF/ID latch, the 32x32 register file, the decoder and the hazard unit.
- Resolves branches and jumps in ID and drives the fetch PC mux inputs.
- Registers all operands and control into the ID/EX latch for the execute stage.

Parameters:
LEN, 32, datapath and PC width (PC is word-addressed).
NB_REG_ADDR, 5, register index width.
N_REGS, 32, register file depth.

Ports:
i_clk  in  1  clock.
i_rst  in  1  synchronous reset, active-high.
i_instruction  in  LEN  instruction from fetch memory.
i_PC  in  LEN  address of i_instruction (fetch o_PC).
i_wb_reg_write  in  1  write-back enable.
i_wb_addr  in  5  write-back register.
i_wb_data  in  LEN  write-back data.
i_exmem_reg_write  in  1  EX/MEM stage writes a register.
i_exmem_rd  in  5  EX/MEM destination.
o_PC_write  out  1  0 = fetch must hold PC (stall).
o_PC_branch  out  LEN  branch target.
o_PCSrc  out  1  take branch.
o_PC_dir_jump  out  LEN  jump target.
o_jump  out  1  take jump.
o_npc  out  LEN  ID/EX: PC+1.
o_rs_data, o_rt_data  out  LEN  ID/EX register operands.
o_imm  out  LEN  ID/EX sign-extended imm16 (zero-extended for ANDI/ORI).
o_rs, o_rt, o_rd  out  5  ID/EX indices; o_rd = 31 for JAL.
o_opcode, o_funct  out  6  ID/EX, for ALU control in EX.
o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_reg_dst, o_link  out  1  ID/EX control.

Behaviour:
- IF/ID latch: captures {i_instruction, i_PC+1} on each edge unless stalled (hold) or flushed (instruction := 0x00000000 NOP, npc held).
- Supported opcodes:
  - R-type 0x00, including JR with funct 0x08.
  - LW 0x23, SW 0x2B.
  - ADDI 0x08, SLTI 0x0A, ANDI 0x0C, ORI 0x0D, LUI 0x0F.
  - BEQ 0x04, BNE 0x05, J 0x02, JAL 0x03.
  - Unknown opcode decodes as NOP: all control bits 0.
- Register file:
  - r0 always reads 0; writes to r0 are ignored.
  - Written on the clock edge when i_wb_reg_write=1.
  - Same-cycle read of i_wb_addr returns i_wb_data (write-through bypass).
- Branch/jump, combinational from IF/ID contents:
  - BEQ/BNE: o_PCSrc=1 when the condition holds; o_PC_branch = npc + sext(imm16), 32-bit wraparound.
  - J/JAL: o_jump=1, o_PC_dir_jump = {6'b0, instr[25:0]}.
  - JR: o_jump=1, o_PC_dir_jump = rs value.
  - A taken branch or jump flushes IF/ID on the same edge.
  - JAL: o_link=1, o_reg_write=1, o_rd=31.
- Load-use stall: ID/EX o_mem_read=1, o_rt≠0, and o_rt equals the current rs or rt.
- Branch/JR operand stall: current instruction is BEQ/BNE/JR and either
  - ID/EX (o_reg_write, dest≠0), or
  - EX/MEM (i_exmem_reg_write, i_exmem_rd≠0)
  writes a register matching rs/rt. ID/EX dest = o_rd if o_reg_dst else o_rt.
- On stall:
  - o_PC_write=0, o_PCSrc=0, o_jump=0.
  - IF/ID holds.
  - ID/EX loads a bubble: all control bits 0, data fields don't-care but driven 0.
  - Stall has priority over flush.
- Latency: an instruction latched into IF/ID at edge N appears on the ID/EX outputs after edge N+1. Branch/jump outputs are valid during the cycle after edge N.
- Reset (i_rst=1 at an edge):
  - IF/ID := NOP, npc 0.
  - All ID/EX outputs 0, all registers 0.
  - After reset: o_PC_write=1, o_PCSrc=0, o_jump=0.
- Reset mid-stall clears the stall condition because ID/EX is zeroed.

Test Plan:
- Reset, then ADDI r1,r0,5 at PC 0 -> two edges later: o_reg_write=1, o_alu_src=1, o_rt=1, o_imm=5, o_npc=1.
- i_wb write r3=0xDEADBEEF while the ID instruction reads r3 -> o_rs_data=0xDEADBEEF (bypass); write to r0 then read -> 0.
- LW r2,0(r0) followed by ADD r4,r2,r2 -> one cycle with o_PC_write=0 and a bubble in ID/EX (all control 0); ADD then issues; no extra stall.
- BEQ r1,r1,+3 at PC 10 with r1 not in flight -> o_PCSrc=1, o_PC_branch=14; next ID instruction is NOP.
- BNE with equal operands -> o_PCSrc=0; BNE whose rs equals i_exmem_rd with i_exmem_reg_write=1 -> stall asserted and o_PCSrc=0 until the hazard clears.
- JAL 0x100 at PC 7 -> o_jump=1, o_PC_dir_jump=0x100, flush; ID/EX o_rd=31, o_link=1, o_npc=8. JR r31 with r31=8 -> o_PC_dir_jump=8.
